mmio_arbiter: RTL and testbench



---
 rtl/mmio_pkg.sv | 14 +
 rtl/mmio_arbiter_if.sv | 39 +++
 rtl/rr_arb2.sv | 14 +
 rtl/mmio_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mmio_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bus arbiter and the peripherals it serves.
package mmio_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} mmio_state_t;

    localparam logic [15:0] MMIO_RD_DFLT      = 16'hA5A5;

    localparam logic [15:0] MMIO_ADDR_SW       = 16'hC001;
    localparam logic [15:0] MMIO_ADDR_SPART_LO = 16'hC004;
    localparam logic [15:0] MMIO_ADDR_SPART_HI = 16'hC007;
    localparam logic [15:0] MMIO_ADDR_BMP_LO   = 16'hC008;
    localparam logic [15:0] MMIO_ADDR_BMP_HI   = 16'hC00A;

endpackage

// File: rtl/mmio_arbiter_if.sv
// Bundles both master request channels and the shared peripheral bus of the arbiter.
interface mmio_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              m0_req,   m1_req;
    logic              m0_we,    m1_we;
    logic [ADDR_W-1:0] m0_addr,  m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_gnt,   m1_gnt;
    logic              m0_done,  m1_done;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;

    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              p_we;
    logic              p_re;
    logic [DATA_W-1:0] p_rdata;
    logic              p_ready;
    logic              timeout_err;

    // Arbiter side: accepts master requests, drives the peripheral bus.
    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  p_rdata, p_ready,
        output m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata,
        output p_addr, p_wdata, p_we, p_re, timeout_err
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata, timeout_err
    );

    modport periph (
        input  p_addr, p_wdata, p_we, p_re,
        output p_rdata, p_ready
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the master not served last wins.
// Purely combinational; the history bit lives in the caller.
module rr_arb2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic vld_o,
    output logic pick_o
);

    assign vld_o  = req0_i | req1_i;
    assign pick_o = (req0_i & req1_i) ? ~last_i : req1_i;

endmodule

// File: rtl/mmio_arbiter.sv
// Two-master MMIO arbiter/sequencer: IDLE->GRANT->(WAIT)->DONE, min 3 cycles per access.
// Waits on p_ready; retires with a default read value after TIMEOUT wait cycles. All outputs registered.
module mmio_arbiter
    import mmio_pkg::*;
#(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 16,
    parameter int                TIMEOUT = 15,
    parameter logic [DATA_W-1:0] RD_DFLT = DATA_W'(MMIO_RD_DFLT)
) (
    input  logic           clk,
    input  logic           rst_n,
    mmio_arbiter_if.slave  bus
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    mmio_state_t       state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              p_we_q, p_we_d;
    logic              p_re_q, p_re_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic              tmo_q, tmo_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              pick_vld, pick;
    logic              sel_we;
    logic              finish, timed_out;
    logic [DATA_W-1:0] rd_val;

    rr_arb2 u_rr_arb2 (
        .req0_i (bus.m0_req),
        .req1_i (bus.m1_req),
        .last_i (last_q),
        .vld_o  (pick_vld),
        .pick_o (pick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            p_we_q   <= 1'b0;
            p_re_q   <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cap_q    <= '0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            p_we_q   <= p_we_d;
            p_re_q   <= p_re_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            cap_q    <= cap_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        p_we_d    = p_we_q;
        p_re_d    = p_re_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        cap_d     = cap_q;
        tmo_d     = 1'b0;
        cnt_d     = cnt_q;
        finish    = 1'b0;
        timed_out = 1'b0;
        sel_we    = pick ? bus.m1_we : bus.m0_we;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    owner_d = pick;
                    we_d    = sel_we;
                    addr_d  = pick ? bus.m1_addr  : bus.m0_addr;
                    wdata_d = pick ? bus.m1_wdata : bus.m0_wdata;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    p_we_d  = sel_we;
                    p_re_d  = ~sel_we;
                end
            end
            GRANT: begin
                if (bus.p_ready) begin
                    finish = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (bus.p_ready) begin
                    finish = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                gnt_d   = '0;
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Writes hand back whatever the last read captured.
        rd_val = we_q ? cap_q : (timed_out ? RD_DFLT : bus.p_rdata);

        if (finish) begin
            state_d         = DONE;
            p_we_d          = 1'b0;
            p_re_d          = 1'b0;
            done_d[owner_q] = 1'b1;
            tmo_d           = timed_out;
            cap_d           = rd_val;
            if (owner_q) rdata1_d = rd_val;
            else         rdata0_d = rd_val;
        end
    end

    assign bus.m0_gnt      = gnt_q[0];
    assign bus.m1_gnt      = gnt_q[1];
    assign bus.m0_done     = done_q[0];
    assign bus.m1_done     = done_q[1];
    assign bus.m0_rdata    = rdata0_q;
    assign bus.m1_rdata    = rdata1_q;
    assign bus.p_addr      = addr_q;
    assign bus.p_wdata     = wdata_q;
    assign bus.p_we        = p_we_q;
    assign bus.p_re        = p_re_q;
    assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: reset, round-robin, zero-wait read, waited write, timeout, mid-access reset, dropped req.
module tb_mmio_arbiter;
    import mmio_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [15:0] r0_exp, r1_exp, cap_exp;

    mmio_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mmio_arbiter #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .TIMEOUT (15),
        .RD_DFLT (16'hA5A5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((bus.m0_gnt & bus.m1_gnt) !== 1'b0) begin
                errors++;
                $display("FAIL gnt_overlap m0_gnt=%b m1_gnt=%b required not both 1", bus.m0_gnt, bus.m1_gnt);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        bus.m0_req = 0; bus.m1_req = 0; bus.m0_we = 0; bus.m1_we = 0;
        bus.m0_addr = 0; bus.m1_addr = 0; bus.m0_wdata = 0; bus.m1_wdata = 0;
        bus.p_rdata = 0; bus.p_ready = 0;
        repeat (2) @(negedge clk);
        checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b want 00", {bus.m0_gnt, bus.m1_gnt}); end
        checks++; if ({bus.m0_done, bus.m1_done} !== 2'b00) begin errors++; $display("FAIL rst_done got %b want 00", {bus.m0_done, bus.m1_done}); end
        checks++; if ({bus.p_we, bus.p_re, bus.timeout_err} !== 3'b000) begin errors++; $display("FAIL rst_strobes got %b want 000", {bus.p_we, bus.p_re, bus.timeout_err}); end
        checks++; if ({bus.p_addr, bus.p_wdata} !== 32'h0) begin errors++; $display("FAIL rst_pbus got %h want 0", {bus.p_addr, bus.p_wdata}); end
        checks++; if ({bus.m0_rdata, bus.m1_rdata} !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", {bus.m0_rdata, bus.m1_rdata}); end
        r0_exp = 0; r1_exp = 0; cap_exp = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        bus.m0_addr = 16'h0010; bus.m1_addr = 16'h0020;
        bus.m0_we = 0; bus.m1_we = 0; bus.p_ready = 1;
        bus.m0_req = 1; bus.m1_req = 1;
        for (int i = 0; i < 4; i++) begin
            logic        own;
            logic [15:0] val;
            own = i[0];
            val = 16'h1000 + 16'(i);
            @(negedge clk);
            checks++; if ({bus.m1_gnt, bus.m0_gnt} !== (own ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_gnt[%0d] got %b want %b", i, {bus.m1_gnt, bus.m0_gnt}, own ? 2'b10 : 2'b01); end
            checks++; if (bus.p_addr !== (own ? 16'h0020 : 16'h0010)) begin errors++; $display("FAIL rr_addr[%0d] got %h want %h", i, bus.p_addr, own ? 16'h0020 : 16'h0010); end
            bus.p_rdata = val;
            @(negedge clk);
            checks++; if ({bus.m1_done, bus.m0_done} !== (own ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_done[%0d] got %b want %b", i, {bus.m1_done, bus.m0_done}, own ? 2'b10 : 2'b01); end
            if (own) r1_exp = val; else r0_exp = val;
            cap_exp = val;
            checks++; if ({bus.m0_rdata, bus.m1_rdata} !== {r0_exp, r1_exp}) begin errors++; $display("FAIL rr_rdata[%0d] got %h want %h", i, {bus.m0_rdata, bus.m1_rdata}, {r0_exp, r1_exp}); end
            @(negedge clk);
            checks++; if ({bus.m1_gnt, bus.m0_gnt, bus.m1_done, bus.m0_done} !== 4'b0) begin errors++; $display("FAIL rr_idle[%0d] got %b want 0000", i, {bus.m1_gnt, bus.m0_gnt, bus.m1_done, bus.m0_done}); end
            if (i == 3) begin bus.m0_req = 0; bus.m1_req = 0; end
        end
        bus.p_ready = 0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = MMIO_ADDR_SW;
        @(negedge clk);
        checks++; if ({bus.m0_gnt, bus.p_re, bus.p_we, bus.m1_gnt} !== 4'b1100) begin errors++; $display("FAIL rd_grant got %b want 1100", {bus.m0_gnt, bus.p_re, bus.p_we, bus.m1_gnt}); end
        checks++; if (bus.p_addr !== 16'hC001) begin errors++; $display("FAIL rd_addr got %h want c001", bus.p_addr); end
        bus.p_ready = 1; bus.p_rdata = 16'h0155;
        @(negedge clk);
        checks++; if ({bus.m0_done, bus.p_re, bus.timeout_err} !== 3'b100) begin errors++; $display("FAIL rd_done got %b want 100", {bus.m0_done, bus.p_re, bus.timeout_err}); end
        checks++; if (bus.m0_rdata !== 16'h0155) begin errors++; $display("FAIL rd_data got %h want 0155", bus.m0_rdata); end
        r0_exp = 16'h0155; cap_exp = 16'h0155;
        bus.p_ready = 0; bus.m0_req = 0;
        @(negedge clk);
        checks++; if ({bus.m0_done, bus.m0_gnt} !== 2'b00) begin errors++; $display("FAIL rd_after got %b want 00", {bus.m0_done, bus.m0_gnt}); end
    endtask

    task automatic test_write_wait();
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = MMIO_ADDR_SPART_LO; bus.m1_wdata = 16'h0041;
        bus.p_ready = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++; if ({bus.p_we, bus.p_re, bus.m1_gnt, bus.m1_done} !== 4'b1010) begin errors++; $display("FAIL wr_cycle[%0d] got %b want 1010", c, {bus.p_we, bus.p_re, bus.m1_gnt, bus.m1_done}); end
            checks++; if ({bus.p_addr, bus.p_wdata} !== {16'hC004, 16'h0041}) begin errors++; $display("FAIL wr_bus[%0d] got %h want c0040041", c, {bus.p_addr, bus.p_wdata}); end
            if (c == 4) bus.p_ready = 1;
        end
        @(negedge clk);
        checks++; if ({bus.m1_done, bus.p_we, bus.m0_done} !== 3'b100) begin errors++; $display("FAIL wr_done got %b want 100", {bus.m1_done, bus.p_we, bus.m0_done}); end
        checks++; if (bus.m1_rdata !== cap_exp) begin errors++; $display("FAIL wr_rdata got %h want %h", bus.m1_rdata, cap_exp); end
        r1_exp = cap_exp;
        bus.p_ready = 0; bus.m1_req = 0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = MMIO_ADDR_BMP_LO; bus.p_ready = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            checks++; if ({bus.m0_gnt, bus.p_re, bus.m0_done, bus.timeout_err} !== 4'b1100) begin errors++; $display("FAIL tmo_wait[%0d] got %b want 1100", c, {bus.m0_gnt, bus.p_re, bus.m0_done, bus.timeout_err}); end
        end
        @(negedge clk);
        checks++; if ({bus.m0_done, bus.timeout_err, bus.p_re} !== 3'b110) begin errors++; $display("FAIL tmo_done got %b want 110", {bus.m0_done, bus.timeout_err, bus.p_re}); end
        checks++; if (bus.m0_rdata !== 16'hA5A5) begin errors++; $display("FAIL tmo_rdata got %h want a5a5", bus.m0_rdata); end
        r0_exp = 16'hA5A5; cap_exp = 16'hA5A5;
        bus.m0_req = 0;
        @(negedge clk);
        checks++; if ({bus.m0_done, bus.timeout_err} !== 2'b00) begin errors++; $display("FAIL tmo_after got %b want 00", {bus.m0_done, bus.timeout_err}); end
    endtask

    task automatic test_reset_mid();
        bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = MMIO_ADDR_SPART_HI; bus.p_ready = 0;
        repeat (3) @(negedge clk);
        checks++; if ({bus.m1_gnt, bus.p_re} !== 2'b11) begin errors++; $display("FAIL rstmid_pre got %b want 11", {bus.m1_gnt, bus.p_re}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.m1_gnt, bus.p_re, bus.p_we} !== 3'b000) begin errors++; $display("FAIL rstmid_async got %b want 000", {bus.m1_gnt, bus.p_re, bus.p_we}); end
        bus.m1_req = 0;
        repeat (2) begin
            @(negedge clk);
            checks++; if ({bus.m0_done, bus.m1_done} !== 2'b00) begin errors++; $display("FAIL rstmid_nodone got %b want 00", {bus.m0_done, bus.m1_done}); end
        end
        r0_exp = 0; r1_exp = 0; cap_exp = 0;
        bus.m0_req = 1; bus.m1_req = 1; bus.m0_we = 0; bus.m0_addr = 16'h0030;
        bus.p_ready = 1; bus.p_rdata = 16'h2222;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({bus.m0_gnt, bus.m1_gnt} !== 2'b10) begin errors++; $display("FAIL rstmid_tie got %b want 10", {bus.m0_gnt, bus.m1_gnt}); end
        @(negedge clk);
        checks++; if ({bus.m0_done, bus.m0_rdata} !== {1'b1, 16'h2222}) begin errors++; $display("FAIL rstmid_done got %h want 12222", {bus.m0_done, bus.m0_rdata}); end
        r0_exp = 16'h2222; cap_exp = 16'h2222;
        bus.m0_req = 0; bus.m1_req = 0; bus.p_ready = 0;
        @(negedge clk);
    endtask

    task automatic test_drop_req();
        int n_done;
        n_done = 0;
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 16'h0040; bus.p_ready = 0;
        repeat (2) @(negedge clk);
        bus.m0_req = 0;
        @(negedge clk);
        bus.p_ready = 1; bus.p_rdata = 16'h3333;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.p_ready = 0;
            if (bus.m0_done === 1'b1) n_done++;
        end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL drop_done_count got %0d want 1", n_done); end
        checks++; if (bus.m0_rdata !== 16'h3333) begin errors++; $display("FAIL drop_rdata got %h want 3333", bus.m0_rdata); end
        checks++; if ({bus.m0_gnt, bus.p_re} !== 2'b00) begin errors++; $display("FAIL drop_idle got %b want 00", {bus.m0_gnt, bus.p_re}); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_round_robin();
        test_single_read();
        test_write_wait();
        test_timeout();
        test_reset_mid();
        test_drop_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
